alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked successor to the team's 8-bit ALU. It collects operands that may arrive together or split across cycles, enforces a bounded wait for the missing operand, and executes arithmetic or logic commands. Results are registered with an explicit valid pulse, and the multiply commands run in a two-cycle path. It sits between the operand/command source and the result consumer in the datapath.

## Interface
- DW, 8, operand width in bits (≥4, power of 2)
- CW, 4, command width
- TIMEOUT, 16, max cycles allowed between first and second operand
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- CE  in  1  clock enable; low = every register holds
- INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid
- OPA, OPB  in  DW  operands
- CIN  in  1  carry/borrow in
- MODE  in  1  1 = arithmetic, 0 = logic
- CMD  in  CW  command
- IN_READY  out  1  block accepts INP_VALID this cycle
- OUT_VALID  out  1  one-cycle result strobe
- RES  out  2*DW  result; non-multiply results zero-extended
- COUT, OFLOW, G, E, L, ERR  out  1 each  flags; all 0 except where a command defines them

## Operation
- FSM states: IDLE, WAIT_A, WAIT_B, EXEC, MUL, TOUT. IN_READY is 1 in IDLE/WAIT_A/WAIT_B and 0 otherwise. INP_VALID is ignored while IN_READY=0.
- IDLE:
  - 11: latch A, B, CMD, MODE, CIN; go to EXEC.
  - 01: latch A plus command fields; go to WAIT_B.
  - 10: latch B plus command fields; go to WAIT_A.
  - 00: stay.
- WAIT_B (WAIT_A is symmetric):
  - 10 or 11: latch OPB only; go to EXEC.
  - 01: re-latch A and command fields; restart the wait counter.
  - 00: counter increments. If the counter has reached TIMEOUT, go to TOUT.
  - A completing operand in the same cycle as expiry wins.
- TOUT: register RES=0, ERR=1, OUT_VALID=1; go to IDLE.
- EXEC: compute and register outputs, OUT_VALID=1, go to IDLE. Exception: multiply commands go to MUL, which registers the product and pulses OUT_VALID, then goes to IDLE.
- Every result load clears all flags not defined by the command. Outputs hold until the next load.
- Arithmetic commands (MODE=1):
  - 0 ADD: A+B, COUT = carry.
  - 1 SUB: A−B mod 2^DW, OFLOW = (A<B).
  - 2 ADDC: A+B+CIN, COUT.
  - 3 SUBB: A−B−CIN, OFLOW = (A < B+CIN).
  - 4 PASS_A.
  - 5 DEC_A, 6 DEC_B, 7 INC_B: results wrap mod 2^DW, no flag.
  - 8 CMP: exactly one of G/E/L = 1, RES=0.
  - 9 MUL_INC: (A+1)·(B+1), full 2*DW bits (A+1 computed at DW+1 bits, product truncated to 2*DW).
  - 10 MUL_SHL: (A<<1 mod 2^DW)·B.
- Logic commands (MODE=0):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 NOT_B.
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B: shifts by one, zero fill.
  - 12 ROL_A, 13 ROR_A: rotate A by B[log2(DW)−1:0]. ERR=1 if any higher bit of B is set; the rotated result is still driven.
- Any other CMD: RES=0, ERR=1, OUT_VALID=1.

## Timing
- Reset (async assert): state IDLE, counter 0, RES=0, all flags 0, OUT_VALID=0, IN_READY=1. Latched operands cleared.
- Reset asserted mid-operation aborts the operation; no OUT_VALID follows.
- Latency from the edge that captures the last operand:
  - Non-multiply: OUT_VALID high after the next edge (1 cycle).
  - Multiply: OUT_VALID high 2 edges later.
- Throughput: one operation every 2 cycles (3 for multiply).
- Split operands: first operand captured at edge N. The second is accepted at edges N+1 … N+TIMEOUT. With no completing operand by edge N+TIMEOUT, TOUT is entered there and the ERR strobe follows 1 cycle later.
- CE=0 freezes state, counter and outputs, including OUT_VALID.

## Configuration
- ALU_MUL_EN defined: MUL state and 2*DW multiplier present.
- ALU_MUL_EN undefined: arithmetic CMD 9/10 behave as invalid commands (ERR=1, 1-cycle latency), MUL state absent, RES upper DW bits tied 0.

## Structure
- Package alu_pipe_pkg: state enum, arithmetic and logic command localparams, default TIMEOUT.
- Sub-module alu_operand_collector: IDLE/WAIT FSM, operand/command latches and timeout counter. Outputs operand-pair-ready or timeout to the execute stage in alu_pipe.

## Test plan
- DW=8, INP_VALID=11, MODE=1, CMD=0, A=200, B=100 -> 1 cycle later OUT_VALID, RES=44, COUT=1, other flags 0.
- INP_VALID=01 with A=5, CMD=1, MODE=1; 3 idle cycles; INP_VALID=10 with B=7 -> RES=254, OFLOW=1, 1 cycle after B is captured.
- INP_VALID=01 then 00 for 16 cycles -> TOUT, OUT_VALID with ERR=1, RES=0; IN_READY=1 on the following cycle. Repeat with B arriving exactly at cycle 16 -> normal result.
- MODE=0, CMD=12, A=8'h81, B=8'h11 -> RES=8'h03, ERR=1; B=8'h01 -> RES=8'h03, ERR=0.
- MODE=1, CMD=9, A=255, B=255 with ALU_MUL_EN -> RES=65536 mod 2^16 = 0 after 2 cycles; without the macro -> ERR=1 after 1 cycle.
- Assert RST in WAIT_B and in MUL -> all outputs 0 immediately, no OUT_VALID; INP_VALID during EXEC is ignored.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for alu_pipe: FSM state encoding, command codes and the
// default operand timeout.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaitA,
        StWaitB,
        StExec,
        StMul,
        StTout
    } alu_state_e;

    localparam int unsigned DefaultTimeout = 16;

    // Arithmetic commands (MODE = 1)
    localparam int unsigned ArAdd    = 0;
    localparam int unsigned ArSub    = 1;
    localparam int unsigned ArAddc   = 2;
    localparam int unsigned ArSubb   = 3;
    localparam int unsigned ArPassA  = 4;
    localparam int unsigned ArDecA   = 5;
    localparam int unsigned ArDecB   = 6;
    localparam int unsigned ArIncB   = 7;
    localparam int unsigned ArCmp    = 8;
    localparam int unsigned ArMulInc = 9;
    localparam int unsigned ArMulShl = 10;

    // Logic commands (MODE = 0)
    localparam int unsigned LgAnd  = 0;
    localparam int unsigned LgNand = 1;
    localparam int unsigned LgOr   = 2;
    localparam int unsigned LgNor  = 3;
    localparam int unsigned LgXor  = 4;
    localparam int unsigned LgXnor = 5;
    localparam int unsigned LgNotA = 6;
    localparam int unsigned LgNotB = 7;
    localparam int unsigned LgShrA = 8;
    localparam int unsigned LgShlA = 9;
    localparam int unsigned LgShrB = 10;
    localparam int unsigned LgShlB = 11;
    localparam int unsigned LgRolA = 12;
    localparam int unsigned LgRorA = 13;

endpackage

// File: rtl/alu_operand_collector.sv
// Operand collector for alu_pipe. Owns the control FSM: gathers operands that
// arrive together or split across cycles, latches the command fields, runs the
// missing-operand timeout and sequences the EXEC/MUL/TOUT stages.
// Ports:
//   clk_i, rst_i, ce_i      clock, async active-high reset, clock enable
//   inp_valid_i             bit0 = opa_i valid, bit1 = opb_i valid
//   opa_i, opb_i, cin_i, mode_i, cmd_i   operand and command inputs
//   mul_i                   latched command is a multiply (from execute stage)
//   in_ready_o              inp_valid_i is accepted this cycle
//   state_o                 current FSM state
//   a_o, b_o, cin_o, mode_o, cmd_o       latched operands and command
module alu_operand_collector
    import alu_pipe_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned CW      = 4,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ce_i,
    input  logic [1:0]    inp_valid_i,
    input  logic [DW-1:0] opa_i,
    input  logic [DW-1:0] opb_i,
    input  logic          cin_i,
    input  logic          mode_i,
    input  logic [CW-1:0] cmd_i,
    input  logic          mul_i,
    output logic          in_ready_o,
    output alu_state_e    state_o,
    output logic [DW-1:0] a_o,
    output logic [DW-1:0] b_o,
    output logic          cin_o,
    output logic          mode_o,
    output logic [CW-1:0] cmd_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    alu_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic          cin_q, cin_d, mode_q, mode_d;
    logic [CW-1:0] cmd_q, cmd_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        mode_d  = mode_q;
        cmd_d   = cmd_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (inp_valid_i != 2'b00) begin
                    cin_d  = cin_i;
                    mode_d = mode_i;
                    cmd_d  = cmd_i;
                    if (inp_valid_i[0]) a_d = opa_i;
                    if (inp_valid_i[1]) b_d = opb_i;
                    unique case (inp_valid_i)
                        2'b01:   state_d = StWaitB;
                        2'b10:   state_d = StWaitA;
                        default: state_d = StExec;
                    endcase
                end
            end
            StWaitB: begin
                // A completing operand beats timeout expiry in the same cycle.
                if (inp_valid_i[1]) begin
                    b_d     = opb_i;
                    cnt_d   = '0;
                    state_d = StExec;
                end else if (inp_valid_i[0]) begin
                    a_d    = opa_i;
                    cin_d  = cin_i;
                    mode_d = mode_i;
                    cmd_d  = cmd_i;
                    cnt_d  = '0;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    state_d = StTout;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitA: begin
                if (inp_valid_i[0]) begin
                    a_d     = opa_i;
                    cnt_d   = '0;
                    state_d = StExec;
                end else if (inp_valid_i[1]) begin
                    b_d    = opb_i;
                    cin_d  = cin_i;
                    mode_d = mode_i;
                    cmd_d  = cmd_i;
                    cnt_d  = '0;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    state_d = StTout;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StExec:  state_d = mul_i ? StMul : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            mode_q  <= 1'b0;
            cmd_q   <= '0;
        end else if (ce_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            mode_q  <= mode_d;
            cmd_q   <= cmd_d;
        end
    end

    assign in_ready_o = (state_q == StIdle) || (state_q == StWaitA) || (state_q == StWaitB);
    assign state_o    = state_q;
    assign a_o        = a_q;
    assign b_o        = b_q;
    assign cin_o      = cin_q;
    assign mode_o     = mode_q;
    assign cmd_o      = cmd_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked, parametrised ALU. Operands are gathered by alu_operand_collector;
// this module executes the latched command and registers RES and flags with a
// one-cycle OUT_VALID strobe. Multiplies take an extra registered stage.
// Macro ALU_MUL_EN: when defined, arithmetic CMD 9/10 run through the MUL
// stage; otherwise they are invalid commands and RES upper half stays 0.
// Ports:
//   CLK, RST (async active-high), CE (clock enable, low freezes all state)
//   INP_VALID, OPA, OPB, CIN, MODE, CMD   operand/command inputs
//   IN_READY                              INP_VALID accepted this cycle
//   OUT_VALID, RES, COUT, OFLOW, G, E, L, ERR   registered result and flags
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned CW      = 4,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE,
    input  logic [1:0]      INP_VALID,
    input  logic [DW-1:0]   OPA,
    input  logic [DW-1:0]   OPB,
    input  logic            CIN,
    input  logic            MODE,
    input  logic [CW-1:0]   CMD,
    output logic            IN_READY,
    output logic            OUT_VALID,
    output logic [2*DW-1:0] RES,
    output logic            COUT,
    output logic            OFLOW,
    output logic            G,
    output logic            E,
    output logic            L,
    output logic            ERR
);

    localparam int unsigned Sw = $clog2(DW);

    alu_state_e    state;
    logic [DW-1:0] a_q, b_q;
    logic          cin_q, mode_q, is_mul;
    logic [CW-1:0] cmd_q;

    alu_operand_collector #(
        .DW      (DW),
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_collector (
        .clk_i       (CLK),
        .rst_i       (RST),
        .ce_i        (CE),
        .inp_valid_i (INP_VALID),
        .opa_i       (OPA),
        .opb_i       (OPB),
        .cin_i       (CIN),
        .mode_i      (MODE),
        .cmd_i       (CMD),
        .mul_i       (is_mul),
        .in_ready_o  (IN_READY),
        .state_o     (state),
        .a_o         (a_q),
        .b_o         (b_q),
        .cin_o       (cin_q),
        .mode_o      (mode_q),
        .cmd_o       (cmd_q)
    );

    // Single-cycle execute datapath for all non-multiply commands.
    logic [DW-1:0] alu_res;
    logic [DW:0]   sum;
    logic [Sw-1:0] sh;
    logic          alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err;

    assign sh = b_q[Sw-1:0];

    always_comb begin
        alu_res   = '0;
        sum       = '0;
        alu_cout  = 1'b0;
        alu_oflow = 1'b0;
        alu_g     = 1'b0;
        alu_e     = 1'b0;
        alu_l     = 1'b0;
        alu_err   = 1'b0;
        if (mode_q) begin
            case (cmd_q)
                CW'(ArAdd): begin
                    sum      = {1'b0, a_q} + {1'b0, b_q};
                    alu_res  = sum[DW-1:0];
                    alu_cout = sum[DW];
                end
                CW'(ArSub): begin
                    alu_res   = a_q - b_q;
                    alu_oflow = a_q < b_q;
                end
                CW'(ArAddc): begin
                    sum      = {1'b0, a_q} + {1'b0, b_q} + {{DW{1'b0}}, cin_q};
                    alu_res  = sum[DW-1:0];
                    alu_cout = sum[DW];
                end
                CW'(ArSubb): begin
                    alu_res   = a_q - b_q - {{(DW-1){1'b0}}, cin_q};
                    alu_oflow = {1'b0, a_q} < ({1'b0, b_q} + {{DW{1'b0}}, cin_q});
                end
                CW'(ArPassA): alu_res = a_q;
                CW'(ArDecA):  alu_res = a_q - DW'(1);
                CW'(ArDecB):  alu_res = b_q - DW'(1);
                CW'(ArIncB):  alu_res = b_q + DW'(1);
                CW'(ArCmp): begin
                    alu_g = a_q > b_q;
                    alu_e = a_q == b_q;
                    alu_l = a_q < b_q;
                end
`ifdef ALU_MUL_EN
                CW'(ArMulInc), CW'(ArMulShl): begin
                end
`endif
                default: alu_err = 1'b1;
            endcase
        end else begin
            case (cmd_q)
                CW'(LgAnd):  alu_res = a_q & b_q;
                CW'(LgNand): alu_res = ~(a_q & b_q);
                CW'(LgOr):   alu_res = a_q | b_q;
                CW'(LgNor):  alu_res = ~(a_q | b_q);
                CW'(LgXor):  alu_res = a_q ^ b_q;
                CW'(LgXnor): alu_res = ~(a_q ^ b_q);
                CW'(LgNotA): alu_res = ~a_q;
                CW'(LgNotB): alu_res = ~b_q;
                CW'(LgShrA): alu_res = {1'b0, a_q[DW-1:1]};
                CW'(LgShlA): alu_res = {a_q[DW-2:0], 1'b0};
                CW'(LgShrB): alu_res = {1'b0, b_q[DW-1:1]};
                CW'(LgShlB): alu_res = {b_q[DW-2:0], 1'b0};
                // A shift by DW (when sh = 0) yields 0, so the OR leaves a_q intact.
                CW'(LgRolA): begin
                    alu_res = (a_q << sh) | (a_q >> (DW - 32'(sh)));
                    alu_err = |b_q[DW-1:Sw];
                end
                CW'(LgRorA): begin
                    alu_res = (a_q >> sh) | (a_q << (DW - 32'(sh)));
                    alu_err = |b_q[DW-1:Sw];
                end
                default: alu_err = 1'b1;
            endcase
        end
    end

`ifdef ALU_MUL_EN
    logic [2*DW-1:0] prod_q, prod_d, prod_n;

    assign is_mul = mode_q && ((cmd_q == CW'(ArMulInc)) || (cmd_q == CW'(ArMulShl)));

    // Operands widened to 2*DW so the product truncates naturally.
    always_comb begin
        if (cmd_q == CW'(ArMulInc)) begin
            prod_n = ((2*DW)'(a_q) + (2*DW)'(1)) * ((2*DW)'(b_q) + (2*DW)'(1));
        end else begin
            prod_n = (2*DW)'({a_q[DW-2:0], 1'b0}) * (2*DW)'(b_q);
        end
        prod_d = ((state == StExec) && is_mul) ? prod_n : prod_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prod_q <= '0;
        end else if (CE) begin
            prod_q <= prod_d;
        end
    end
`else
    assign is_mul = 1'b0;
`endif

    // Result registers: every load rewrites all flags; otherwise they hold.
    logic [2*DW-1:0] res_q, res_d;
    logic cout_q, cout_d, oflow_q, oflow_d, g_q, g_d, e_q, e_d, l_q, l_d, err_q, err_d;
    logic out_valid_q, out_valid_d;

    always_comb begin
        res_d       = res_q;
        cout_d      = cout_q;
        oflow_d     = oflow_q;
        g_d         = g_q;
        e_d         = e_q;
        l_d         = l_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        case (state)
            StExec: begin
                if (!is_mul) begin
                    res_d       = {{DW{1'b0}}, alu_res};
                    cout_d      = alu_cout;
                    oflow_d     = alu_oflow;
                    g_d         = alu_g;
                    e_d         = alu_e;
                    l_d         = alu_l;
                    err_d       = alu_err;
                    out_valid_d = 1'b1;
                end
            end
`ifdef ALU_MUL_EN
            StMul: begin
                res_d       = prod_q;
                {cout_d, oflow_d, g_d, e_d, l_d, err_d} = '0;
                out_valid_d = 1'b1;
            end
`endif
            StTout: begin
                res_d       = '0;
                {cout_d, oflow_d, g_d, e_d, l_d} = '0;
                err_d       = 1'b1;
                out_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            res_q       <= '0;
            cout_q      <= 1'b0;
            oflow_q     <= 1'b0;
            g_q         <= 1'b0;
            e_q         <= 1'b0;
            l_q         <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (CE) begin
            res_q       <= res_d;
            cout_q      <= cout_d;
            oflow_q     <= oflow_d;
            g_q         <= g_d;
            e_q         <= e_d;
            l_q         <= l_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign RES       = res_q;
    assign COUT      = cout_q;
    assign OFLOW     = oflow_q;
    assign G         = g_q;
    assign E         = e_q;
    assign L         = l_q;
    assign ERR       = err_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (DW=8, TIMEOUT=16).
module tb_alu_pipe;

    logic        CLK = 1'b0;
    logic        RST, CE, CIN, MODE;
    logic [1:0]  INP_VALID;
    logic [7:0]  OPA, OPB;
    logic [3:0]  CMD;
    logic        IN_READY, OUT_VALID, COUT, OFLOW, G, E, L, ERR;
    logic [15:0] RES;

    int n_checks = 0;
    int n_errors = 0;

    alu_pipe #(
        .DW      (8),
        .CW      (4),
        .TIMEOUT (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE        (CE),
        .INP_VALID (INP_VALID),
        .OPA       (OPA),
        .OPB       (OPB),
        .CIN       (CIN),
        .MODE      (MODE),
        .CMD       (CMD),
        .IN_READY  (IN_READY),
        .OUT_VALID (OUT_VALID),
        .RES       (RES),
        .COUT      (COUT),
        .OFLOW     (OFLOW),
        .G         (G),
        .E         (E),
        .L         (L),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // flags = {COUT, OFLOW, G, E, L, ERR}
    task automatic expect_out(input string tag, input logic v, input logic [15:0] res,
                              input logic [5:0] flags);
        check({tag, ".valid"}, 32'(OUT_VALID), 32'(v));
        check({tag, ".res"}, 32'(RES), 32'(res));
        check({tag, ".flags"}, 32'({COUT, OFLOW, G, E, L, ERR}), 32'(flags));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic m, input logic [3:0] cmd);
        INP_VALID = iv;
        OPA       = a;
        OPB       = b;
        CIN       = c;
        MODE      = m;
        CMD       = cmd;
    endtask

    // Both operands together; result checked one edge after capture.
    task automatic one_shot(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic c, input logic m, input logic [3:0] cmd,
                            input logic [15:0] res, input logic [5:0] flags);
        drive(2'b11, a, b, c, m, cmd);
        tick();
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        tick();
        expect_out(tag, 1'b1, res, flags);
    endtask

    initial begin
        RST = 1'b1;
        CE  = 1'b1;
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        #1;
        expect_out("reset", 1'b0, 16'h0, 6'b0);
        check("reset.in_ready", 32'(IN_READY), 32'd1);
        tick();
        RST = 1'b0;
        tick();

        // ADD 200+100 -> 44 carry out
        drive(2'b11, 8'd200, 8'd100, 1'b0, 1'b1, 4'd0);
        tick();
        check("add.busy_ready", 32'(IN_READY), 32'd0);
        check("add.early_valid", 32'(OUT_VALID), 32'd0);
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        tick();
        expect_out("add", 1'b1, 16'd44, 6'b100000);
        tick();
        check("add.strobe_off", 32'(OUT_VALID), 32'd0);
        check("add.hold_res", 32'(RES), 32'd44);

        // Split SUB 5-7; OPA change while waiting for B must be ignored
        drive(2'b01, 8'd5, 8'd0, 1'b0, 1'b1, 4'd1);
        tick();
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        repeat (3) tick();
        check("sub.wait_ready", 32'(IN_READY), 32'd1);
        drive(2'b10, 8'd99, 8'd7, 1'b0, 1'b0, 4'd0);
        tick();
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        tick();
        expect_out("sub_split", 1'b1, 16'd254, 6'b010000);

        // Timeout: 16 idle cycles after A
        drive(2'b01, 8'd1, 8'd0, 1'b0, 1'b1, 4'd0);
        tick();
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        repeat (15) tick();
        check("tout.still_wait", 32'(IN_READY), 32'd1);
        tick();
        check("tout.entered", 32'(IN_READY), 32'd0);
        tick();
        expect_out("tout", 1'b1, 16'd0, 6'b000001);
        check("tout.ready_after", 32'(IN_READY), 32'd1);

        // B arriving on the last allowed edge completes normally
        drive(2'b01, 8'd3, 8'd0, 1'b0, 1'b1, 4'd0);
        tick();
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        repeat (15) tick();
        drive(2'b10, 8'd0, 8'd4, 1'b0, 1'b0, 4'd0);
        tick();
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        tick();
        expect_out("late_b", 1'b1, 16'd7, 6'b0);

        // Split with B first (WAIT_A), SUBB 10-3-1
        drive(2'b10, 8'd0, 8'd3, 1'b1, 1'b1, 4'd3);
        tick();
        drive(2'b01, 8'd10, 8'd0, 1'b0, 1'b0, 4'd0);
        tick();
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        tick();
        expect_out("subb_split", 1'b1, 16'd6, 6'b0);

        one_shot("addc", 8'd255, 8'd0, 1'b1, 1'b1, 4'd2, 16'd0, 6'b100000);
        one_shot("subb_borrow", 8'd4, 8'd4, 1'b1, 1'b1, 4'd3, 16'd255, 6'b010000);
        one_shot("dec_a", 8'd0, 8'd9, 1'b0, 1'b1, 4'd5, 16'd255, 6'b0);
        one_shot("inc_b", 8'd0, 8'd255, 1'b0, 1'b1, 4'd7, 16'd0, 6'b0);
        one_shot("cmp_l", 8'd5, 8'd9, 1'b0, 1'b1, 4'd8, 16'd0, 6'b000010);
        one_shot("cmp_e", 8'd9, 8'd9, 1'b0, 1'b1, 4'd8, 16'd0, 6'b000100);
        one_shot("xor", 8'h0f, 8'hff, 1'b0, 1'b0, 4'd4, 16'h00f0, 6'b0);
        one_shot("nand", 8'hf0, 8'h3c, 1'b0, 1'b0, 4'd1, 16'h00cf, 6'b0);
        one_shot("shl1_b", 8'h00, 8'h81, 1'b0, 1'b0, 4'd11, 16'h0002, 6'b0);
        one_shot("rol_err", 8'h81, 8'h11, 1'b0, 1'b0, 4'd12, 16'h0003, 6'b000001);
        one_shot("rol_ok", 8'h81, 8'h01, 1'b0, 1'b0, 4'd12, 16'h0003, 6'b0);
        one_shot("ror", 8'h81, 8'h03, 1'b0, 1'b0, 4'd13, 16'h0030, 6'b0);
        one_shot("bad_logic", 8'h12, 8'h34, 1'b0, 1'b0, 4'd14, 16'h0, 6'b000001);
        one_shot("bad_arith", 8'h12, 8'h34, 1'b0, 1'b1, 4'd12, 16'h0, 6'b000001);

        // Multiply commands
`ifdef ALU_MUL_EN
        drive(2'b11, 8'd255, 8'd255, 1'b0, 1'b1, 4'd9);
        tick();
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        tick();
        check("mul.stage1_valid", 32'(OUT_VALID), 32'd0);
        tick();
        expect_out("mul_inc_wrap", 1'b1, 16'd0, 6'b0);
        drive(2'b11, 8'd2, 8'd3, 1'b0, 1'b1, 4'd9);
        tick();
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        repeat (2) tick();
        expect_out("mul_inc", 1'b1, 16'd12, 6'b0);
        drive(2'b11, 8'd200, 8'd5, 1'b0, 1'b1, 4'd10);
        tick();
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        repeat (2) tick();
        expect_out("mul_shl", 1'b1, 16'd720, 6'b0);
`else
        one_shot("mul_inc_off", 8'd255, 8'd255, 1'b0, 1'b1, 4'd9, 16'd0, 6'b000001);
        one_shot("mul_shl_off", 8'd2, 8'd3, 1'b0, 1'b1, 4'd10, 16'd0, 6'b000001);
`endif

        // Load a nonzero result, then reset while in WAIT_B
        one_shot("pre_rst", 8'd20, 8'd1, 1'b0, 1'b1, 4'd0, 16'd21, 6'b0);
        drive(2'b01, 8'd9, 8'd0, 1'b0, 1'b1, 4'd0);
        tick();
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        tick();
        RST = 1'b1;
        #1;
        expect_out("rst_waitb", 1'b0, 16'd0, 6'b0);
        check("rst_waitb.ready", 32'(IN_READY), 32'd1);
        RST = 1'b0;
        repeat (2) tick();
        check("rst_waitb.no_valid", 32'(OUT_VALID), 32'd0);

        // Reset while executing an ADD
        one_shot("pre_rst2", 8'd1, 8'd1, 1'b0, 1'b1, 4'd0, 16'd2, 6'b0);
        drive(2'b11, 8'd1, 8'd2, 1'b0, 1'b1, 4'd0);
        tick();
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        RST = 1'b1;
        #1;
        expect_out("rst_exec", 1'b0, 16'd0, 6'b0);
        RST = 1'b0;
        tick();
        check("rst_exec.no_valid", 32'(OUT_VALID), 32'd0);

`ifdef ALU_MUL_EN
        one_shot("pre_rst3", 8'd1, 8'd1, 1'b0, 1'b1, 4'd0, 16'd2, 6'b0);
        drive(2'b11, 8'd2, 8'd3, 1'b0, 1'b1, 4'd9);
        tick();
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        tick();
        RST = 1'b1;
        #1;
        expect_out("rst_mul", 1'b0, 16'd0, 6'b0);
        RST = 1'b0;
        tick();
        check("rst_mul.no_valid", 32'(OUT_VALID), 32'd0);
`endif

        // INP_VALID during EXEC is ignored
        drive(2'b11, 8'd1, 8'd2, 1'b0, 1'b1, 4'd0);
        tick();
        drive(2'b11, 8'd10, 8'd20, 1'b0, 1'b1, 4'd0);
        tick();
        expect_out("exec_ignore", 1'b1, 16'd3, 6'b0);
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        tick();
        check("exec_ignore.no_extra", 32'(OUT_VALID), 32'd0);
        check("exec_ignore.idle", 32'(IN_READY), 32'd1);

        // CE=0 freezes state and outputs, including the strobe
        drive(2'b11, 8'd7, 8'd8, 1'b0, 1'b1, 4'd0);
        tick();
        drive(2'b00, 8'h0, 8'h0, 1'b0, 1'b0, 4'h0);
        CE = 1'b0;
        repeat (2) tick();
        check("ce.frozen_valid", 32'(OUT_VALID), 32'd0);
        check("ce.frozen_ready", 32'(IN_READY), 32'd0);
        CE = 1'b1;
        tick();
        expect_out("ce_resume", 1'b1, 16'd15, 6'b0);
        CE = 1'b0;
        tick();
        check("ce.strobe_held", 32'(OUT_VALID), 32'd1);
        CE = 1'b1;
        tick();
        check("ce.strobe_off", 32'(OUT_VALID), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
